// File: rtl/bsg_beat_assembler.sv
// Collects els_p narrow beats, first beat in the LSBs, into one wide word.
// The full word is held until it is taken with yumi_i or dropped with clear_i.
module bsg_beat_assembler #(
    parameter int width_p = 4,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    input  logic                       clear_i,
    output logic                       valid_o,
    output logic [width_p*els_p-1:0]   data_o,
    input  logic                       yumi_i
);

    localparam int count_w_lp = $clog2(els_p);
    localparam logic [count_w_lp-1:0] last_count_lp = count_w_lp'(els_p - 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]                state_r, state_n;
    logic [count_w_lp-1:0]     count_r, count_n;
    logic [width_p*els_p-1:0]  data_r,  data_n;

    assign ready_o = (state_r == FILL) & ~clear_i & ~reset_i;
    assign valid_o = (state_r == FULL);
    assign data_o  = data_r;

    // clear_i wins over both beat acceptance and yumi_i; the word bits are left as-is
    always_comb begin
        state_n = state_r;
        count_n = count_r;
        data_n  = data_r;
        if (clear_i) begin
            state_n = FILL;
            count_n = '0;
        end else if (state_r == FILL) begin
            if (valid_i) begin
                data_n[count_r*width_p +: width_p] = data_i;
                if (count_r == last_count_lp) begin
                    count_n = '0;
                    state_n = FULL;
                end else begin
                    count_n = count_r + 1'b1;
                end
            end
        end else if (yumi_i) begin
            state_n = FILL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= FILL;
            count_r <= '0;
            data_r  <= '0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            data_r  <= data_n;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !valid_o))
            else $error("bsg_beat_assembler: yumi_i asserted while valid_o is low");
        end
    end
`endif

endmodule

// File: doc/bsg_beat_assembler.md
BSG_BEAT_ASSEMBLER -- requirements
Module: bsg_beat_assembler

Interface
REQ-001 SHALL have parameter width_p, default 4, giving the input beat width in bits.
REQ-002 SHALL have parameter els_p, default 4, giving the number of beats per assembled word; legal range 2 to 16.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port valid_i, input, 1 bit: beat on data_i is valid.
REQ-006 SHALL have port data_i, input, width_p bits: input beat.
REQ-007 SHALL have port ready_o, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port clear_i, input, 1 bit: discard the partial or complete word.
REQ-009 SHALL have port valid_o, output, 1 bit: data_o holds a complete word.
REQ-010 SHALL have port data_o, output, width_p*els_p bits: the assembled word, which feeds a downstream enable register.
REQ-011 SHALL have port yumi_i, input, 1 bit: the consumer takes data_o this cycle; it is legal only when valid_o=1.

Function
REQ-012 SHALL implement two states, FILL and FULL, plus a beat counter count_r of width $clog2(els_p).
REQ-013 SHALL drive ready_o = (state==FILL) & ~clear_i & ~reset_i; ready_o SHALL NOT depend on yumi_i.
REQ-014 SHALL accept a beat when valid_i & ready_o: write data_i into data_o bits [count_r*width_p +: width_p] and increment count_r.
REQ-015 SHALL hold the assembled word little-endian: the first beat occupies the LSBs.
REQ-016 SHALL handle acceptance with count_r==els_p-1 as follows: next state FULL, count_r wraps to 0, and valid_o=1 from the following cycle (1-cycle latency from the last beat).
REQ-017 SHALL ignore valid_i while ready_o=0; no register changes.
REQ-018 SHALL hold data_o and valid_o stable in FULL until yumi_i or clear_i.
REQ-019 SHALL handle yumi_i=1 in FULL as follows: next state FILL, valid_o=0 and ready_o=1 on the next cycle; peak throughput is one word per els_p+1 cycles.
REQ-020 SHALL drive valid_o = (state==FULL) directly from a register, with no combinational input-to-output path.
REQ-021 SHALL handle clear_i=1 in any state as follows: next state FILL, count_r=0; a beat presented in the same cycle is not accepted.
REQ-022 SHALL give clear_i priority over yumi_i when both are asserted in FULL; the resulting state is FILL, count_r=0.
REQ-023 SHALL leave data_o bits unchanged on clear_i; stale bits are overwritten by subsequent beats.
REQ-024 SHALL keep data_o equal to the internal word register at all times; its contents are meaningful only when valid_o=1.
REQ-025 SHALL flag yumi_i=1 while valid_o=0 with a simulation assertion; the RTL SHALL then leave state unchanged.

Reset
REQ-026 SHALL, while reset_i=1 at a clock edge, set state=FILL, count_r=0, data_o=0 and valid_o=0.
REQ-027 SHALL hold ready_o=0 during reset_i=1 and drive ready_o=1 on the first cycle after reset_i falls, provided clear_i=0.
REQ-028 SHALL, when reset is asserted mid-word or in FULL, discard all progress and return to the REQ-026 values on the next edge.

Verification
REQ-029 SHALL cover basic assembly (width_p=4, els_p=4): beats 0x1, 0x2, 0x3, 0x4 on consecutive cycles -> valid_o=1 the cycle after the 4th beat, data_o=0x4321, ready_o=0.
REQ-030 SHALL cover backpressure: hold FULL with yumi_i=0 for 10 cycles while valid_i=1 with data 0xF -> data_o stays 0x4321; yumi_i -> next cycle ready_o=1, valid_o=0.
REQ-031 SHALL cover clear mid-word: beats 0xA, 0xB, then clear_i=1 with valid_i=1 data 0xC -> beat 0xC dropped; then beats 0x5, 0x6, 0x7, 0x8 -> data_o=0x8765.
REQ-032 SHALL cover simultaneous clear_i and yumi_i in FULL: next cycle valid_o=0, ready_o=1; a following 4-beat word assembles correctly.
REQ-033 SHALL cover reset mid-operation: reset_i after 2 beats -> data_o=0, valid_o=0 and ready_o=0 during reset; after reset, 4 fresh beats -> correct word with no residue.
REQ-034 SHALL cover a random stress run with a scoreboard: random valid_i, yumi_i and rare clear_i for at least 10k cycles with els_p in {2, 3, 16} -> every consumed word matches the reference model, and the REQ-025 assertion never fires.
